// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 slave with an 8 x 8-bit register file.
// reg0..reg6 are read/write; reg7 is a read-only status byte
// {STATUS_RST[7:2], gpx_in, irq_in}. Each transaction is one command byte
// (bit7 = write, bits[2:0] = address) followed by any number of data bytes.
// Build option: define SPI_SLAVE_AUTOINC_EN to step the address after every
// data byte (wrapping 7->0); otherwise the address holds for the transaction.
module spi_slave_regs #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] STATUS_RST  = 8'h00
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       spi_SCLK,
  input  logic       spi_SS_n,
  input  logic       spi_MOSI,
  output logic       spi_MISO,
  output logic       spi_MISO_oe,
  input  logic       irq_in,
  input  logic       gpx_in,
  output logic [7:0] keycode_export,
  output logic       wr_strobe,
  output logic [2:0] wr_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Synchronizer chains; the SS_n chain idles high so reset looks deselected
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] ss_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   sclk_d_reg;
  logic                   ss_d_reg;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall;

  // Transaction datapath
  logic [2:0] bit_cnt_reg;
  logic [6:0] rx_shift_reg;
  logic [7:0] rx_byte;
  logic       is_write_reg;
  logic [2:0] addr_reg;
  logic       load_pending_reg;
  logic [7:0] tx_shift_reg;
  logic [7:0] status_reg;
  logic       wr_strobe_reg;
  logic [2:0] wr_addr_reg;

  logic       in_cmd, in_data, active;
  logic       byte_done;
  logic       reg_we;
  logic [7:0] rd_mux [8];
  logic [7:0] rd_data;

  assign sclk_s  = sclk_sync_reg[SYNC_STAGES-1];
  assign ss_s    = ss_sync_reg[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_reg[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
  assign ss_fall   = ~ss_s & ss_d_reg;

  // Bring the SPI pins into clk_clk and keep one delayed copy for edge detection
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_sync_reg <= '0;
      ss_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sclk_d_reg    <= 1'b0;
      ss_d_reg      <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_SCLK};
      ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], spi_SS_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_MOSI};
      sclk_d_reg    <= sclk_s;
      ss_d_reg      <= ss_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_reg <= IDLE;
    else                state_reg <= state_next;
  end

  // FSM next state: a deselect returns to IDLE from anywhere
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ss_fall) state_next = CMD;
      CMD:     if (ss_s) state_next = IDLE;
               else if (byte_done) state_next = DATA;
      DATA:    if (ss_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: phase qualifiers, only true while still selected
  always_comb begin
    in_cmd  = 1'b0;
    in_data = 1'b0;
    case (state_reg)
      CMD:     in_cmd  = ~ss_s;
      DATA:    in_data = ~ss_s;
      default: ;
    endcase
  end

  assign active    = in_cmd | in_data;
  assign byte_done = active & sclk_rise & (bit_cnt_reg == 3'd7);
  assign rx_byte   = {rx_shift_reg, mosi_s};
  assign reg_we    = in_data & byte_done & is_write_reg;

  // Status byte is resampled every clock
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) status_reg <= {STATUS_RST[7:2], 2'b00};
    else                status_reg <= {STATUS_RST[7:2], gpx_in, irq_in};
  end

  // Receive side: bit counting, command decode, address stepping, write strobe
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bit_cnt_reg      <= 3'd0;
      rx_shift_reg     <= 7'd0;
      is_write_reg     <= 1'b0;
      addr_reg         <= 3'd0;
      load_pending_reg <= 1'b0;
      wr_strobe_reg    <= 1'b0;
      wr_addr_reg      <= 3'd0;
    end else begin
      wr_strobe_reg <= 1'b0;
      if (!active) begin
        // A partial byte is simply forgotten when the master deselects
        bit_cnt_reg      <= 3'd0;
        load_pending_reg <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_shift_reg <= {rx_shift_reg[5:0], mosi_s};
          bit_cnt_reg  <= bit_cnt_reg + 3'd1;
        end
        if (sclk_fall) load_pending_reg <= 1'b0;
        if (byte_done) begin
          load_pending_reg <= 1'b1;
          if (in_cmd) begin
            is_write_reg <= rx_byte[7];
            addr_reg     <= rx_byte[2:0];
          end else begin
            if (is_write_reg && (addr_reg != 3'd7)) begin
              wr_strobe_reg <= 1'b1;
              wr_addr_reg   <= addr_reg;
            end
`ifdef SPI_SLAVE_AUTOINC_EN
            addr_reg <= addr_reg + 3'd1;
`endif
          end
        end
      end
    end
  end

  // Writable registers; address 7 has no storage so writes to it vanish
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_regs
      logic [7:0] data_reg;
      // Commit the received byte when it completes in a write transaction
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)                          data_reg <= 8'h00;
        else if (reg_we && (addr_reg == 3'(gi)))     data_reg <= rx_byte;
      end
      assign rd_mux[gi] = data_reg;
    end
  endgenerate

  assign rd_mux[7] = status_reg;
  assign rd_data   = rd_mux[addr_reg];

  // Transmit shifter: tracks status while idle so the SS_n fall freezes it,
  // then shifts on SCLK falls and reloads from the register file per byte
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_shift_reg <= 8'h00;
    end else if (state_reg == IDLE) begin
      tx_shift_reg <= status_reg;
    end else if (active && sclk_fall) begin
      if (load_pending_reg) tx_shift_reg <= rd_data;
      else                  tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
    end
  end

  assign spi_MISO_oe    = ~ss_s;
  assign spi_MISO       = ~ss_s & tx_shift_reg[7];
  assign keycode_export = rd_mux[0];
  assign wr_strobe      = wr_strobe_reg;
  assign wr_addr        = wr_addr_reg;

endmodule
